sprite_rom_arbiter: RTL and testbench



---
 rtl/sprite_pkg.sv | 12 +
 rtl/sprite_rom_arbiter_rr_arbiter.sv | 43 ++++
 rtl/sprite_rom_arbiter.sv | 104 ++++++++++
 tb/tb_sprite_rom_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Sprite ROM geometry defaults shared by the road sprite fetch path.
package sprite_pkg;

   localparam int SPR_W  = 135;
   localparam int SPR_H  = 40;
   localparam int ADDR_W = 13;
   localparam int X_W    = 8;
   localparam int Y_W    = 6;

   typedef logic [ADDR_W-1:0] sprite_addr_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request above the last accepted index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               accept,
   output logic [ID_W-1:0]    gnt_id
);

   logic [ID_W-1:0] ptr_r;
   logic            found_s;

   // Scan upward from ptr+1; no grant at all while reset is held.
   always_comb begin
      gnt     = {NUM_REQ{1'b0}};
      gnt_id  = {ID_W{1'b0}};
      found_s = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found_s && Reset_n && req[(int'(ptr_r) + k) % NUM_REQ]) begin
            gnt[(int'(ptr_r) + k) % NUM_REQ] = 1'b1;
            gnt_id  = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      accept = found_s;
   end

   // Pointer remembers the last accepted requester.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_r <= ID_W'(NUM_REQ - 1);
      end else if (accept) begin
         ptr_r <= gnt_id;
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares the single-port road sprite ROM between pixel fetch units with a
// two-stage id/out-of-range tag pipeline matching the ROM read latency.
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int SPR_W   = sprite_pkg::SPR_W,
   parameter int SPR_H   = sprite_pkg::SPR_H,
   parameter int ADDR_W  = sprite_pkg::ADDR_W,
   parameter int X_W     = sprite_pkg::X_W,
   parameter int Y_W     = sprite_pkg::Y_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*X_W-1:0] req_x,
   input  logic [NUM_REQ*Y_W-1:0] req_y,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic                   rom_data,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_data
);

   logic [NUM_REQ-1:0] gnt_s;
   logic               accept_s;
   logic [ID_W-1:0]    gnt_id_s;
   logic [X_W-1:0]     sel_x_s;
   logic [Y_W-1:0]     sel_y_s;
   logic [ADDR_W-1:0]  addr_s;
   logic               oob_s;

   logic [ADDR_W-1:0]  rom_addr_r;
   logic               s1_valid_r;
   logic [ID_W-1:0]    s1_id_r;
   logic               s1_oob_r;
   logic               s2_valid_r;
   logic [ID_W-1:0]    s2_id_r;
   logic               s2_oob_r;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .req     (req),
      .gnt     (gnt_s),
      .accept  (accept_s),
      .gnt_id  (gnt_id_s)
   );

   assign gnt = gnt_s;

   // Grant is one-hot, so an AND-OR mux picks the winner's coordinates.
   always_comb begin
      sel_x_s = {X_W{1'b0}};
      sel_y_s = {Y_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_x_s = sel_x_s | (req_x[i*X_W +: X_W] & {X_W{gnt_s[i]}});
         sel_y_s = sel_y_s | (req_y[i*Y_W +: Y_W] & {Y_W{gnt_s[i]}});
      end
      addr_s = ADDR_W'(sel_y_s) * ADDR_W'(SPR_W) + ADDR_W'(sel_x_s);
      oob_s  = (int'(sel_x_s) >= SPR_W) || (int'(sel_y_s) >= SPR_H);
   end

   // Address stage: out-of-range fetches leave the ROM address untouched.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr_r <= {ADDR_W{1'b0}};
         s1_valid_r <= 1'b0;
         s1_id_r    <= {ID_W{1'b0}};
         s1_oob_r   <= 1'b0;
      end else begin
         s1_valid_r <= accept_s;
         s1_id_r    <= accept_s ? gnt_id_s : {ID_W{1'b0}};
         s1_oob_r   <= accept_s & oob_s;
         if (accept_s && !oob_s) begin
            rom_addr_r <= addr_s;
         end
      end
   end

   // ROM stage: tags advance alongside the ROM's internal data register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s2_valid_r <= 1'b0;
         s2_id_r    <= {ID_W{1'b0}};
         s2_oob_r   <= 1'b0;
      end else begin
         s2_valid_r <= s1_valid_r;
         s2_id_r    <= s1_id_r;
         s2_oob_r   <= s1_oob_r;
      end
   end

   assign rom_addr  = rom_addr_r;
   assign rsp_valid = s2_valid_r;
   assign rsp_id    = s2_valid_r ? s2_id_r : {ID_W{1'b0}};
   assign rsp_data  = s2_valid_r & ~s2_oob_r & rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench: expected grants per cycle; responses checked by a scoreboard monitor.
module tb_sprite_rom_arbiter;
   import sprite_pkg::*;

   logic         Clk;
   logic         Reset_n;
   logic [3:0]   req;
   logic [31:0]  req_x;
   logic [23:0]  req_y;
   logic [3:0]   gnt;
   sprite_addr_t rom_addr;
   logic         rom_data;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic         rsp_data;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc_cnt  = 0;
   logic        mem [0:8191];

   typedef struct packed {
      logic [1:0]  id;
      logic        d;
      logic [31:0] c;
   } exp_t;
   exp_t sb [$];

   sprite_rom_arbiter dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req       (req),
      .req_x     (req_x),
      .req_y     (req_y),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

   // Sprite ROM model: one-cycle registered read.
   initial rom_data = 1'b0;
   always @(posedge Clk) rom_data <= mem[rom_addr];

   function automatic logic rom_bit(input int i);
      logic [12:0] a;
      a = i[12:0];
      return ~(a[0] ^ a[3] ^ a[7]);
   endfunction

   function automatic logic [31:0] px(input int i, input int v);
      logic [31:0] t;
      t = 32'(v & 255) << (i * 8);
      return t;
   endfunction

   function automatic logic [23:0] py(input int i, input int v);
      logic [23:0] t;
      t = 24'(v & 63) << (i * 6);
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One stimulus cycle: drive, check the grant, queue the expected response.
   task automatic cyc(input logic [3:0] r, input logic [31:0] xs, input logic [23:0] ys,
                      input logic [3:0] exp_g, input bit expect_rsp);
      int          id;
      int          x;
      int          y;
      exp_t        e;
      @(negedge Clk);
      req   = r;
      req_x = xs;
      req_y = ys;
      #1;
      chk("gnt", 32'(gnt), 32'(exp_g));
      if (exp_g != 4'b0000 && expect_rsp) begin
         id = 0;
         for (int i = 0; i < 4; i++) if (exp_g[i]) id = i;
         x = int'(xs[id*8 +: 8]);
         y = int'(ys[id*6 +: 6]);
         e.id = id[1:0];
         e.d  = (x >= 135 || y >= 40) ? 1'b0 : mem[y * 135 + x];
         e.c  = cyc_cnt + 32'd2;
         sb.push_back(e);
      end
   endtask

   // Response monitor: every valid response must match the oldest queued entry.
   always @(negedge Clk) begin
      exp_t e;
      if (rsp_valid !== 1'b0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp: got id %0d valid %b, expected no response", rsp_id, rsp_valid);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.d));
            chk("rsp_cycle", cyc_cnt, e.c);
         end
      end
   end

   initial begin
      logic [31:0] xs;
      logic [23:0] ys;
      for (int i = 0; i < 8192; i++) mem[i] = rom_bit(i);
      req     = 4'b0000;
      req_x   = 32'd0;
      req_y   = 24'd0;
      Reset_n = 1'b0;

      // Reset state, with requests present to show gnt is suppressed
      repeat (2) @(negedge Clk);
      req = 4'b1111;
      #1;
      chk("gnt_in_reset", 32'(gnt), 32'd0);
      chk("rsp_valid_reset", 32'(rsp_valid), 32'd0);
      chk("rom_addr_reset", 32'(rom_addr), 32'd0);
      chk("rsp_id_reset", 32'(rsp_id), 32'd0);
      chk("rsp_data_reset", 32'(rsp_data), 32'd0);
      @(negedge Clk);
      req     = 4'b0000;
      Reset_n = 1'b1;

      // Origin pixel from requester 0
      cyc(4'b0001, px(0, 0), py(0, 0), 4'b0001, 1'b1);
      cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);
      chk("rom_addr_origin", 32'(rom_addr), 32'd0);

      // Out-of-range x then y: address holds, data forced to 0
      cyc(4'b0010, px(1, 135), py(1, 0), 4'b0010, 1'b1);
      cyc(4'b0010, px(1, 0), py(1, 40), 4'b0010, 1'b1);
      chk("rom_addr_oob_x", 32'(rom_addr), 32'd0);
      cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);
      chk("rom_addr_oob_y", 32'(rom_addr), 32'd0);

      // Last pixel of the sprite
      cyc(4'b0100, px(2, 134), py(2, 39), 4'b0100, 1'b1);
      cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);
      chk("rom_addr_last", 32'(rom_addr), 32'd5399);

      // Park the pointer on requester 3
      cyc(4'b1000, px(3, 7), py(3, 3), 4'b1000, 1'b1);

      // All requesters held high: strict rotation 0,1,2,3,...
      for (int k = 0; k < 8; k++) begin
         xs = 32'd0;
         ys = 24'd0;
         for (int i = 0; i < 4; i++) begin
            xs = xs | px(i, k * 16 + i);
            ys = ys | py(i, k * 4 + i);
         end
         cyc(4'b1111, xs, ys, 4'b0001 << (k % 4), 1'b1);
      end
      repeat (3) cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);
      chk("drain_rotation", 32'(sb.size()), 32'd0);

      // Reset in flight: the accepted fetch must never answer
      cyc(4'b1000, px(3, 10), py(3, 2), 4'b1000, 1'b0);
      @(negedge Clk);
      Reset_n = 1'b0;
      req     = 4'b1111;
      #1;
      chk("gnt_mid_reset", 32'(gnt), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      req     = 4'b0000;
      repeat (3) cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);

      // Pointer back at 3: requester 0 wins first, then 3
      cyc(4'b1001, px(0, 1) | px(3, 2), py(0, 1) | py(3, 1), 4'b0001, 1'b1);
      cyc(4'b1001, px(0, 1) | px(3, 2), py(0, 1) | py(3, 1), 4'b1000, 1'b1);

      // Requester 2 loses to 1, then drops: no response for 2
      cyc(4'b0110, px(1, 20) | px(2, 21), py(1, 5) | py(2, 6), 4'b0010, 1'b1);
      cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);
      repeat (3) cyc(4'b0000, 32'd0, 24'd0, 4'b0000, 1'b0);
      chk("drain_final", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
